// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrating output mux.
package mux_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned NMin         = 2;
    localparam int unsigned NMax         = 16;

    // Ceiling log2, evaluated at elaboration time for port widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin grant: one-hot grant to the first asserted request at or after ptr, wrapping.
// With ptr tied to zero this degenerates to lowest-index fixed priority.
module rr_arb
    import mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    localparam int unsigned SumW = SEL_W + 1;

    logic [SumW-1:0] w_idx;
    logic            w_found;

    // Walk ptr, ptr+1, ... modulo N; wrap is an explicit subtract so non-power-of-two N works.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = {1'b0, ptr} + SumW'(k);
            if (w_idx >= SumW'(N)) begin
                w_idx = w_idx - SumW'(N);
            end
            if (!w_found && req[w_idx[SEL_W-1:0]]) begin
                grant[w_idx[SEL_W-1:0]] = 1'b1;
                w_found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrating mux with a single registered output stage (latency 1, full throughput).
// Define ARB_MUX_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module arb_mux
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = clog2(N)
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    if ((N < NMin) || (N > NMax)) begin : g_n_range_check
        $error("arb_mux: N outside supported range");
    end

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_sel;

    logic             w_load;
    logic             w_xfer;
    logic [N-1:0]     w_grant;
    logic [SEL_W-1:0] w_gidx;
    logic [WIDTH-1:0] w_word;
    logic [SEL_W-1:0] w_ptr;

    assign w_load = !r_valid || out_ready;
    assign w_xfer = w_load && (|w_grant);

    // Gated by clrn so nothing is accepted while reset is held.
    assign in_ready = (w_load && clrn) ? w_grant : '0;

    rr_arb #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arb (
        .req   (in_valid),
        .ptr   (w_ptr),
        .grant (w_grant)
    );

    // Encode the one-hot grant and select the granted word (AND-OR mux).
    always_comb begin
        w_gidx = '0;
        w_word = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_gidx = w_gidx | SEL_W'(i);
                w_word = w_word | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [SEL_W-1:0] r_ptr;

    // Priority pointer moves just past the winner, only on an input transfer.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gidx == SEL_W'(N - 1)) ? '0 : w_gidx + SEL_W'(1);
        end
    end

    assign w_ptr = r_ptr;
`endif

    // Output register: loads when empty or draining; data/sel hold when nothing is granted.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_load) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= w_word;
                r_sel  <= w_gidx;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Directed, table-driven bench for arb_mux (N=4 main instance, N=3 wrap instance).
// Expectations follow ARB_MUX_FIXED_PRIO_EN when the macro is defined.
module tb_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         clrn;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    logic [2:0]   iv3;
    logic [95:0]  id3;
    logic [2:0]   ir3;
    logic         ov3;
    logic [31:0]  od3;
    logic [1:0]   os3;
    logic         or3;

    arb_mux #(.WIDTH(32), .N(4)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    arb_mux #(.WIDTH(32), .N(3)) dut3 (
        .clk       (clk),
        .clrn      (clrn),
        .in_valid  (iv3),
        .in_data   (id3),
        .in_ready  (ir3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_sel   (os3),
        .out_ready (or3)
    );

    typedef struct {
        logic [3:0]   iv;
        logic [127:0] dat;
        logic         ordy;
        logic [3:0]   ir;
        logic         ov;
        logic [1:0]   sel;
        logic [31:0]  od;
    } vec_t;

    vec_t vecs[$];
    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] DStd = {32'h13, 32'h12, 32'h11, 32'h10};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] iv, input logic [127:0] dat, input logic ordy,
                       input logic [3:0] ir, input logic ov, input logic [1:0] sel,
                       input logic [31:0] od);
        vec_t v;
        v.iv = iv; v.dat = dat; v.ordy = ordy; v.ir = ir; v.ov = ov; v.sel = sel; v.od = od;
        vecs.push_back(v);
    endtask

    initial begin
        logic [1:0] exp3_sel[4];
        logic [2:0] exp3_ir[4];

`ifndef ARB_MUX_FIXED_PRIO_EN
        add(4'b0001, {32'h13, 32'h12, 32'h11, 32'h0A}, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0A);
        add(4'b1000, DStd, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h13);
        add(4'b1111, DStd, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h10);
        add(4'b1111, DStd, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h11);
        add(4'b1111, DStd, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h12);
        add(4'b1111, DStd, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h13);
        add(4'b1111, DStd, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h10);
        add(4'b0010, {32'h13, 32'h12, 32'h20, 32'h10}, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h20);
        for (int i = 0; i < 3; i++) add(4'b0100, DStd, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h20);
        add(4'b0100, DStd, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h12);
        add(4'b0000, DStd, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h12);
        add(4'b0000, DStd, 1'b0, 4'b0000, 1'b0, 2'd2, 32'h12);
        add(4'b0001, DStd, 1'b0, 4'b0001, 1'b1, 2'd0, 32'h10);
        add(4'b0000, DStd, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h10);
        add(4'b0101, DStd, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h12);
        add(4'b0011, DStd, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h10);
        exp3_sel = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp3_ir  = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        add(4'b0001, {32'h13, 32'h12, 32'h11, 32'h0A}, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0A);
        for (int i = 0; i < 4; i++) add(4'b1010, DStd, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h11);
        add(4'b1010, DStd, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h11);
        add(4'b1100, DStd, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h12);
        add(4'b0000, DStd, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h12);
        add(4'b0011, DStd, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h10);
        exp3_sel = '{2'd0, 2'd0, 2'd0, 2'd0};
        exp3_ir  = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif

        // Reset held, requests present: nothing accepted, outputs cleared.
        clrn      = 1'b0;
        in_valid  = 4'b1111;
        in_data   = DStd;
        out_ready = 1'b1;
        iv3       = 3'b000;
        id3       = {32'h32, 32'h31, 32'h30};
        or3       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        clrn     = 1'b1;
        in_valid = 4'b0000;

        foreach (vecs[i]) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].dat;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            check($sformatf("v%0d_out_sel", i), 32'(out_sel), 32'(vecs[i].sel));
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].od);
        end

        // Asynchronous reset mid-stream with a word held.
        in_valid  = 4'b1111;
        in_data   = DStd;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #1 clrn = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data", out_data, 32'd0);
        check("async_rst_out_sel", 32'(out_sel), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 clrn = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd1);
        check("post_rst_out_sel", 32'(out_sel), 32'd0);
        check("post_rst_out_data", out_data, 32'h10);
        in_valid = 4'b0000;

        // N=3 instance: wrap from index 2 back to 0.
        iv3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("n3_c%0d_in_ready", i), 32'(ir3), 32'(exp3_ir[i]));
            @(posedge clk);
            #1;
            check($sformatf("n3_c%0d_out_valid", i), 32'(ov3), 32'd1);
            check($sformatf("n3_c%0d_out_sel", i), 32'(os3), 32'(exp3_sel[i]));
            check($sformatf("n3_c%0d_out_data", i), od3, 32'h30 + 32'(exp3_sel[i]));
        end
        iv3 = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter N, default 4, input channel count, legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default clog2(N), width of out_sel.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  N  per-channel request.
REQ-007 SHALL have port in_data  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_ready  output  N  per-channel accept, combinational.
REQ-009 SHALL have port out_valid  output  1  output register holds a word.
REQ-010 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-011 SHALL have port out_sel  output  SEL_W  index of the channel that supplied out_data.
REQ-012 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-013 load = !out_valid || out_ready; the output register SHALL load only when load=1.
REQ-014 Grant SHALL be one-hot among asserted in_valid bits; grant SHALL be zero when no in_valid is asserted.
REQ-015 in_ready[i] SHALL equal load && grant[i]; at most one in_ready bit high per cycle.
REQ-016 Transfer on channel i occurs when in_valid[i] && in_ready[i]; out_data/out_sel SHALL show that word/index on the next cycle with out_valid=1 (latency 1).
REQ-017 Output transfer occurs when out_valid && out_ready; a simultaneous new load SHALL replace the word the same edge (one word per cycle sustained).
REQ-018 When load=1 and no input valid, out_valid SHALL go 0; out_data and out_sel SHALL hold their previous values.
REQ-019 When out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold; all in_ready SHALL be 0.
REQ-020 Round-robin: pointer ptr (SEL_W bits) gives highest priority; search order ptr, ptr+1, ... wrapping N-1 -> 0.
REQ-021 On each input transfer from channel g, ptr SHALL become (g+1) mod N; for N not a power of two, wrap SHALL be explicit, never via bit overflow.
REQ-022 ptr SHALL not change on cycles without an input transfer.
REQ-023 in_valid deasserted without a transfer SHALL be legal (no latching of requests).

Reset
REQ-024 On clrn low, asynchronously: out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-025 Reset mid-operation SHALL discard the held word; no in_ready SHALL be asserted while clrn=0.
REQ-026 First grant after reset SHALL favour channel 0.

Configuration
REQ-027 Macro ARB_MUX_FIXED_PRIO_EN defined: fixed priority, lowest valid index wins, ptr logic removed, REQ-020..022 do not apply.
REQ-028 Macro undefined: round-robin per REQ-020..022.

Structure
REQ-029 Shared package/header mux_pkg SHALL hold default WIDTH (32), the clog2 function and the N range limits.
REQ-030 Grant logic SHALL be sub-module rr_arb (inputs req, ptr; output one-hot grant); arb_mux holds ptr and the output register.

Verification
REQ-031 Reset, then in_valid=4'b0001, in_data ch0=32'h0000000A, out_ready=1 -> next cycle out_valid=1, out_data=0xA, out_sel=0.
REQ-032 in_valid=4'b1111 held, out_ready=1, ch i data=0x10+i -> out_sel sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-033 out_valid=1 holding 0x20, out_ready=0 for 3 cycles with in_valid=4'b0100 -> in_ready=0, out_data stays 0x20; out_ready=1 -> ch2 word appears next cycle.
REQ-034 N=3, in_valid=3'b111 -> out_sel 0,1,2,0 (wrap from 2 to 0, no index 3).
REQ-035 clrn pulsed low mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately (no clock); next grant goes to channel 0.
REQ-036 With ARB_MUX_FIXED_PRIO_EN, in_valid=4'b1010 held, out_ready=1 -> out_sel=1 every cycle.
